// File: rtl/freq_sweep_ctrl_pkg.sv
// Shared definitions for the frequency-sweep controller and the mean-current block.
// The measure-window length is also used by the mean-current block.
package freq_sweep_ctrl_pkg;
    localparam int FW_DEF = 16;
    localparam int CNT_W  = 20;
    localparam int CURR_W = 12;
    localparam int IDX_W  = 8;

    localparam logic [CNT_W-1:0] SETTLE_DEF = 20'd1000;
    localparam logic [CNT_W-1:0] MEAS_DEF   = 20'h9C40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_SETTLE,
        ST_MEASURE,
        ST_CAPTURE,
        ST_NEXT,
        ST_DONE
    } state_t;
endpackage

// File: rtl/freq_sweep_ctrl_peak_tracker.sv
// Registered peak search: keeps the largest current seen and the frequency it occurred at.
// Strictly-greater compare, so on a tie the earlier (lower) frequency is kept.
module peak_tracker
    import freq_sweep_ctrl_pkg::*;
#(
    parameter int             FW       = FW_DEF,
    parameter logic [FW-1:0]  CLR_FREQ = '0
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [FW-1:0]     i_freq,
    input  logic [CURR_W-1:0] i_curr,
    output logic [FW-1:0]     o_best_freq,
    output logic [CURR_W-1:0] o_best_curr
);
    logic [FW-1:0]     r_best_freq;
    logic [CURR_W-1:0] r_best_curr;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_best_freq <= CLR_FREQ;
            r_best_curr <= '0;
        end else if (i_en && (i_curr > r_best_curr)) begin
            r_best_freq <= i_freq;
            r_best_curr <= i_curr;
        end
    end

    assign o_best_freq = r_best_freq;
    assign o_best_curr = r_best_curr;
endmodule

// File: rtl/freq_sweep_ctrl.sv
// Sweeps the inverter frequency word, settling and measuring at each point,
// and reports the frequency that produced the highest mean current.
module freq_sweep_ctrl
    import freq_sweep_ctrl_pkg::*;
#(
    parameter int               FW            = FW_DEF,
    parameter logic [FW-1:0]    F_START       = 16'd100,
    parameter logic [FW-1:0]    F_STOP        = 16'd200,
    parameter logic [FW-1:0]    F_STEP        = 16'd1,
    parameter logic [CNT_W-1:0] SETTLE_CYCLES = SETTLE_DEF,
    parameter logic [CNT_W-1:0] MEAS_CYCLES   = MEAS_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              swiptAlive,
    input  logic              start,
    input  logic [CURR_W-1:0] mean_curr,
    output logic [FW-1:0]     freq_word,
    output logic              measure,
    output logic              busy,
    output logic              done,
    output logic [FW-1:0]     best_freq,
    output logic [CURR_W-1:0] best_curr,
    output logic [IDX_W-1:0]  point_idx
);
    // A zero count is treated as one cycle, so the reload value is then zero as well.
    localparam logic [CNT_W-1:0] SETTLE_LD = (SETTLE_CYCLES == '0) ? '0 : SETTLE_CYCLES - 1'b1;
    localparam logic [CNT_W-1:0] MEAS_LD   = (MEAS_CYCLES == '0) ? '0 : MEAS_CYCLES - 1'b1;

    state_t           r_state;
    logic [FW-1:0]    r_freq;
    logic             r_measure;
    logic             r_busy;
    logic             r_done;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;

    logic             w_kill;
    logic             w_accept;
    logic             w_clr;
    logic [FW:0]      w_sum;
    logic             w_last;

    assign w_kill   = !nrst || !swiptAlive;
    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_clr    = w_kill || w_accept;

    // Carry bit catches wrap past the top of the frequency word.
    assign w_sum  = {1'b0, r_freq} + {1'b0, F_STEP};
    assign w_last = w_sum[FW] || (w_sum[FW-1:0] > F_STOP);

    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_state   <= ST_IDLE;
            r_freq    <= F_START;
            r_measure <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SET;
                        r_freq  <= F_START;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_SET: begin
                    r_cnt   <= SETTLE_LD;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_cnt     <= MEAS_LD;
                        r_measure <= 1'b1;
                        r_state   <= ST_MEASURE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (r_cnt == '0) begin
                        r_measure <= 1'b0;
                        r_state   <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_freq  <= w_sum[FW-1:0];
                        if (r_idx != '1) begin
                            r_idx <= r_idx + 1'b1;
                        end
                        r_state <= ST_SET;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    peak_tracker #(
        .FW       (FW),
        .CLR_FREQ (F_START)
    ) u_peak (
        .clk         (clk),
        .i_clr       (w_clr),
        .i_en        (r_state == ST_CAPTURE),
        .i_freq      (r_freq),
        .i_curr      (mean_curr),
        .o_best_freq (best_freq),
        .o_best_curr (best_curr)
    );

    assign freq_word = r_freq;
    assign measure   = r_measure;
    assign busy      = r_busy;
    assign done      = r_done;
    assign point_idx = r_idx;
endmodule
